// File: rtl/demux_deser_pkg.sv
// Shared sizing helpers for the serial demultiplexer/deserializer.
// Optional parity mode: DEMUX_DESER_PARITY_EN adds one even-parity bit per word.
package demux_deser_pkg;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r++;
    end
    return r;
  endfunction

  function automatic int sel_width(input int nch);
    return clog2_int(nch);
  endfunction

  // Serial bits per word, including the trailing parity bit when enabled.
  function automatic int word_len(input int width);
`ifdef DEMUX_DESER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_width(input int width);
    return clog2_int(word_len(width));
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One deserializer lane: shift register, bit counter, output word, valid and error pulses.
// Honours DEMUX_DESER_PARITY_EN (parity bit checked after the data bits).
module demux_lane
  import demux_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             en,
  input  logic             frm,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic             qv,
  output logic             err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(word_len(WIDTH) - 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (srst) begin
      sr  <= '0;
      cnt <= '0;
      q   <= '0;
      qv  <= 1'b0;
      err <= 1'b0;
    end else begin
      qv  <= 1'b0;
      err <= 1'b0;
      if (en) begin
        if (frm) begin
          // Restart: this bit is bit 0; any partial word is dropped and flagged.
          sr  <= {sr[WIDTH-2:0], d};
          cnt <= CW'(1);
          err <= (cnt != '0);
        end else if (cnt == LAST) begin
          cnt <= '0;
`ifdef DEMUX_DESER_PARITY_EN
          if ((^sr) == d) begin
            q  <= sr;
            qv <= 1'b1;
          end else begin
            err <= 1'b1;
          end
`else
          sr <= {sr[WIDTH-2:0], d};
          q  <= {sr[WIDTH-2:0], d};
          qv <= 1'b1;
`endif
        end else begin
          sr  <= {sr[WIDTH-2:0], d};
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/demux_deser.sv
// Serial 1:NCH demultiplexer/deserializer: steers tagged bits into per-channel lanes.
// Optional parity check per word when DEMUX_DESER_PARITY_EN is defined.
module demux_deser
  import demux_deser_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = sel_width(NCH)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 D,
  input  logic                 V,
  input  logic [SELW-1:0]      S,
  input  logic                 FRM,
  output logic [NCH*WIDTH-1:0] Q,
  output logic [NCH-1:0]       QV,
  output logic                 ERR
);

  logic [NCH-1:0] lane_err;
  logic           sel_err;

  // Selects past the last channel only exist when NCH is not a power of two.
  always_ff @(posedge CLK) begin
    if (RST) sel_err <= 1'b0;
    else     sel_err <= V && (int'(S) >= NCH);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      demux_lane #(.WIDTH(WIDTH)) u_lane (
        .clk  (CLK),
        .srst (RST),
        .en   (V && (int'(S) == gi)),
        .frm  (FRM),
        .d    (D),
        .q    (Q[gi*WIDTH +: WIDTH]),
        .qv   (QV[gi]),
        .err  (lane_err[gi])
      );
    end
  endgenerate

  assign ERR = sel_err | (|lane_err);

endmodule
